// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state, forwarding and scoreboard encodings for the hazard scheduler
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_FREEZE  = 2'd3
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  // EX/MEM wins over MEM/WB because it carries the younger write.
  function automatic fwd_sel_e fwd_pick(input logic ex_alu_hit, input logic mem_hit);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (ex_alu_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// rtl/hazard_sb_entry.sv - one scoreboard entry with source-register match compares
module hazard_sb_entry
  import pipe_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  sb_entry_t  entry_d_i,
  input  logic       use_a_i,
  input  logic [4:0] rs_a_i,
  input  logic       use_b_i,
  input  logic [4:0] rs_b_i,
  output sb_entry_t  entry_q_o,
  output logic       hit_a_o,
  output logic       hit_b_o
);

  sb_entry_t entry_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else if (en_i) begin
      entry_q <= entry_d_i;
    end
  end

  // x0 is hardwired, so it never matches a producer.
  assign hit_a_o   = entry_q.valid && use_a_i && (rs_a_i != 5'd0) && (rs_a_i == entry_q.rd);
  assign hit_b_o   = entry_q.valid && use_b_i && (rs_b_i != 5'd0) && (rs_b_i == entry_q.rd);
  assign entry_q_o = entry_q;

endmodule

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - pipeline hazard FSM and forwarding select; HAZARD_PERF_CNT_EN adds stall/flush counters
module hazard_scheduler
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_is_load,
  input  logic        redirect,
  input  logic        mem_busy,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  hz_state_e state_q, state_d;
  sb_entry_t sb_ex_d, sb_ex_q, sb_mem_unused;
  logic      ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic      load_use;

  assign sb_ex_d.valid   = id_valid && id_regwrite && (id_rd != 5'd0) && !stall_id && !flush_ex;
  assign sb_ex_d.rd      = id_rd;
  assign sb_ex_d.is_load = id_is_load;

  hazard_sb_entry u_sb_ex (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (!mem_busy),
    .entry_d_i (sb_ex_d),
    .use_a_i   (id_use_rs1),
    .rs_a_i    (id_rs1),
    .use_b_i   (id_use_rs2),
    .rs_b_i    (id_rs2),
    .entry_q_o (sb_ex_q),
    .hit_a_o   (ex_hit_a),
    .hit_b_o   (ex_hit_b)
  );

  hazard_sb_entry u_sb_mem (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (!mem_busy),
    .entry_d_i (sb_ex_q),
    .use_a_i   (id_use_rs1),
    .rs_a_i    (id_rs1),
    .use_b_i   (id_use_rs2),
    .rs_b_i    (id_rs2),
    .entry_q_o (sb_mem_unused),
    .hit_a_o   (mem_hit_a),
    .hit_b_o   (mem_hit_b)
  );

  assign fwd_a    = fwd_pick(ex_hit_a && !sb_ex_q.is_load, mem_hit_a);
  assign fwd_b    = fwd_pick(ex_hit_b && !sb_ex_q.is_load, mem_hit_b);
  assign load_use = (ex_hit_a || ex_hit_b) && sb_ex_q.is_load;
  assign state    = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FREEZE with memory ready behaves as RUN so a hazard held across the freeze is still resolved.
  always_comb begin
    state_d  = state_q;
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (rst) begin
      state_d = ST_RUN;
    end else if (mem_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      state_d  = ST_FREEZE;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          flush_ex = 1'b1;
          state_d  = ST_RUN;
        end
        ST_LDSTALL: begin
          if (redirect) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
            state_d  = ST_FLUSH;
          end else begin
            state_d  = ST_RUN;
          end
        end
        default: begin
          if (redirect) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
            state_d  = ST_FLUSH;
          end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
            state_d  = ST_LDSTALL;
          end else begin
            state_d  = ST_RUN;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, stall_id};
      flush_cnt_q <= flush_cnt_q + {31'd0, flush_id};
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - directed and randomized check of hazard_scheduler against a behavioural model
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       redirect, mem_busy;
  logic       stall_if, stall_id, flush_id, flush_ex;
  logic [1:0] fwd_a, fwd_b, state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_is_load  (id_is_load),
    .redirect    (redirect),
    .mem_busy    (mem_busy),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .flush_id    (flush_id),
    .flush_ex    (flush_ex),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .state       (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // Model: the two in-flight writers, and what the previous edge did (which is what the state reports).
  typedef struct {bit v; bit [4:0] rd; bit ld;} ent_t;
  ent_t      m_ex, m_mem;
  int        m_st;
  bit [31:0] m_scnt, m_fcnt;
  bit        e_sif, e_sid, e_fid, e_fex;
  bit [1:0]  e_fa, e_fb;
  int        nvec = 0;
  int        nmis = 0;

  task automatic model_reset();
    m_ex   = '{0, 0, 0};
    m_mem  = '{0, 0, 0};
    m_st   = 0;
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  function automatic bit [1:0] fwd_of(bit u, bit [4:0] rs);
    if (!u || rs == 0) return 2'b00;
    if (m_ex.v && !m_ex.ld && m_ex.rd == rs) return 2'b01;
    if (m_mem.v && m_mem.rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit lu_of(bit u, bit [4:0] rs);
    return u && rs != 0 && m_ex.v && m_ex.ld && m_ex.rd == rs;
  endfunction

  task automatic model_outputs();
    bit lu;
    {e_sif, e_sid, e_fid, e_fex} = 4'b0;
    e_fa = 0;
    e_fb = 0;
    if (rst) begin
      model_reset();
      return;
    end
    e_fa = fwd_of(id_use_rs1, id_rs1);
    e_fb = fwd_of(id_use_rs2, id_rs2);
    lu   = lu_of(id_use_rs1, id_rs1) || lu_of(id_use_rs2, id_rs2);
    if (mem_busy) begin
      e_sif = 1; e_sid = 1;
    end else if (m_st == 2) begin
      e_fex = 1;
    end else if (redirect) begin
      e_fid = 1; e_fex = 1;
    end else if (lu) begin
      e_sif = 1; e_sid = 1; e_fex = 1;
    end
  endtask

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_cycle();
    #4;
    model_outputs();
    cmp("stall_if", stall_if, e_sif);
    cmp("stall_id", stall_id, e_sid);
    cmp("flush_id", flush_id, e_fid);
    cmp("flush_ex", flush_ex, e_fex);
    cmp("fwd_a", fwd_a, e_fa);
    cmp("fwd_b", fwd_b, e_fb);
    cmp("state", state, m_st);
`ifdef HAZARD_PERF_CNT_EN
    cmp("stall_cnt", stall_cnt, m_scnt);
    cmp("flush_cnt", flush_cnt, m_fcnt);
`endif
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_scnt += e_sid;
      m_fcnt += e_fid;
      if (mem_busy) begin
        m_st = 3;
      end else begin
        m_mem = m_ex;
        if (id_valid && id_regwrite && id_rd != 0 && !e_sid && !e_fex) m_ex = '{1, id_rd, id_is_load};
        else m_ex = '{0, 0, 0};
        m_st = e_fid ? 2 : (e_sid ? 1 : 0);
      end
    end
    #1;
  endtask

  task automatic step();
    check_cycle();
    clk_edge();
  endtask

  task automatic idle();
    {id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load} = 5'b0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    redirect = 0; mem_busy = 0;
  endtask

  task automatic instr(bit v, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2, bit [4:0] rd, bit wr, bit ld);
    idle();
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = wr; id_is_load = ld;
  endtask

  task automatic all_zero(string nm);
    cmp({nm, "_outs"}, {stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b}, 0);
    cmp({nm, "_state"}, state, 0);
`ifdef HAZARD_PERF_CNT_EN
    cmp({nm, "_cnts"}, stall_cnt | flush_cnt, 0);
`endif
  endtask

  initial begin
    model_reset();
    instr(1, 3, 1, 3, 1, 3, 1, 1);
    rst = 1; redirect = 1; mem_busy = 1;
    #2;
    all_zero("reset_hold");
    @(posedge clk); #1;
    step();
    rst = 0; idle();
    step();
    check_cycle();
    cmp("post_reset_run", state, 0);
    clk_edge();

    // ALU back-to-back
    instr(1, 0, 0, 0, 0, 5, 1, 0); step();
    instr(1, 5, 1, 0, 0, 9, 1, 0); check_cycle();
    cmp("alu_fwd_a", fwd_a, 2'b01);
    cmp("alu_no_stall", stall_id, 0);
    clk_edge();
    idle(); step(); step();

    // load-use
    instr(1, 0, 0, 0, 0, 6, 1, 1); step();
    instr(1, 6, 1, 0, 0, 10, 1, 0); check_cycle();
    cmp("ldu_stall", {stall_if, stall_id, flush_ex, flush_id}, 4'b1110);
    cmp("ldu_state_run", state, 0);
    clk_edge();
    check_cycle();
    cmp("ldu_state_ldstall", state, 1);
    cmp("ldu_fwd_memwb", fwd_a, 2'b10);
    cmp("ldu_released", stall_id, 0);
    clk_edge();
    idle(); check_cycle();
    cmp("ldu_back_run", state, 0);
    clk_edge(); step();

    // redirect together with load-use
    instr(1, 0, 0, 0, 0, 7, 1, 1); step();
    instr(1, 0, 0, 7, 1, 11, 1, 0); redirect = 1; check_cycle();
    cmp("redir_flush", {flush_id, flush_ex, stall_id}, 3'b110);
    clk_edge();
    idle(); check_cycle();
    cmp("redir_state_flush", state, 2);
    cmp("redir_flush_ex_only", {flush_id, flush_ex}, 2'b01);
    clk_edge(); check_cycle();
    cmp("redir_back_run", state, 0);
    clk_edge();

    // mem_busy for three cycles on top of a load-use
    instr(1, 0, 0, 0, 0, 8, 1, 1); step();
    instr(1, 8, 1, 0, 0, 12, 1, 0); mem_busy = 1; check_cycle();
    cmp("busy_stall", {stall_if, stall_id, flush_id, flush_ex}, 4'b1100);
    clk_edge();
    for (int i = 0; i < 2; i++) begin
      check_cycle();
      cmp("busy_freeze", state, 3);
      cmp("busy_sb_held", fwd_a, 2'b00);
      clk_edge();
    end
    mem_busy = 0; check_cycle();
    cmp("busy_then_ldu", {stall_id, flush_ex}, 2'b11);
    clk_edge(); check_cycle();
    cmp("busy_ldstall", state, 1);
    cmp("busy_ldstall_fwd", fwd_a, 2'b10);
    clk_edge();
    idle(); step(); step();

    // x0 writer and reader
    instr(1, 0, 0, 0, 0, 0, 1, 1); step();
    instr(1, 0, 1, 0, 1, 13, 1, 0); check_cycle();
    cmp("x0_fwd", {fwd_a, fwd_b}, 4'b0000);
    cmp("x0_no_stall", stall_id, 0);
    clk_edge();
    idle(); step(); step();

    // reset pulsed mid-FREEZE
    mem_busy = 1; step(); step();
    check_cycle();
    cmp("freeze_before_rst", state, 3);
    #1 rst = 1;
    #1 all_zero("rst_in_freeze");
    clk_edge();
    rst = 0; idle();
    step();

    // randomized traffic on a small register window so hazards are frequent
    for (int n = 0; n < 3000; n++) begin
      id_valid    = ($urandom_range(0, 9) < 8);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      id_rd       = 5'($urandom_range(0, 3));
      id_regwrite = ($urandom_range(0, 9) < 7);
      id_is_load  = ($urandom_range(0, 9) < 4);
      redirect    = ($urandom_range(0, 7) == 0);
      mem_busy    = ($urandom_range(0, 5) == 0);
      rst         = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
